axi_rr_arbiter: RTL

- Shares the single CL3Top AXI4 master port (io_master_*) between NREQ internal requesters, for example the instruction fetch unit and the LSU.
- Read and write directions are arbitrated independently with round-robin fairness.
- Each direction holds at most one outstanding transaction, so responses are routed by the locked grant and IDs pass through unmodified.

---
 rtl/axi_rr_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: shares one AXI4 master port between NREQ requesters.
// Reads and writes are arbitrated independently, round-robin, one outstanding transaction each.
module axi_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int IDW  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NREQ-1:0]                  s_ar_valid,
  output logic [NREQ-1:0]                  s_ar_ready,
  input  logic [NREQ*(AW+IDW+13)-1:0]      s_ar_bits,
  output logic [NREQ-1:0]                  s_r_valid,
  input  logic [NREQ-1:0]                  s_r_ready,
  output logic [DW+IDW+2:0]                s_r_bits,
  input  logic [NREQ-1:0]                  s_aw_valid,
  output logic [NREQ-1:0]                  s_aw_ready,
  input  logic [NREQ*(AW+IDW+13)-1:0]      s_aw_bits,
  input  logic [NREQ-1:0]                  s_w_valid,
  output logic [NREQ-1:0]                  s_w_ready,
  input  logic [NREQ*(DW+DW/8+1)-1:0]      s_w_bits,
  output logic [NREQ-1:0]                  s_b_valid,
  input  logic [NREQ-1:0]                  s_b_ready,
  output logic [IDW+1:0]                   s_b_bits,
  output logic                             m_ar_valid,
  input  logic                             m_ar_ready,
  output logic [AW+IDW+12:0]               m_ar_bits,
  input  logic                             m_r_valid,
  output logic                             m_r_ready,
  input  logic [DW+IDW+2:0]                m_r_bits,
  output logic                             m_aw_valid,
  input  logic                             m_aw_ready,
  output logic [AW+IDW+12:0]               m_aw_bits,
  output logic                             m_w_valid,
  input  logic                             m_w_ready,
  output logic [DW+DW/8:0]                 m_w_bits,
  input  logic                             m_b_valid,
  output logic                             m_b_ready,
  input  logic [IDW+1:0]                   m_b_bits
);
  localparam int ABW = AW + IDW + 13;
  localparam int WBW = DW + DW / 8 + 1;
  localparam int GW  = $clog2(NREQ);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  r_state_t r_st, r_nxt;
  w_state_t w_st, w_nxt;
  logic [GW-1:0] rgnt, rgnt_nxt, rd_ptr, rd_ptr_nxt;
  logic [GW-1:0] wgnt, wgnt_nxt, wr_ptr, wr_ptr_nxt;
  logic [WBW-1:0] w_sel;
  // lowest-offset requester at or after the pointer wins
  function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [GW-1:0] p);
    logic [GW-1:0] g, k;
    g = p;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = GW'((int'(p) + i) % NREQ);
      if (v[k]) g = k;
    end
    return g;
  endfunction
  function automatic logic [GW-1:0] nxt_ptr(input logic [GW-1:0] g);
    return g == GW'(NREQ - 1) ? '0 : g + GW'(1);
  endfunction
  assign m_ar_bits = s_ar_bits[int'(rgnt)*ABW +: ABW];
  assign m_aw_bits = s_aw_bits[int'(wgnt)*ABW +: ABW];
  assign w_sel     = s_w_bits[int'(wgnt)*WBW +: WBW];
  assign m_w_bits  = w_sel;
  assign s_r_bits  = m_r_bits;
  assign s_b_bits  = m_b_bits;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= R_IDLE;
      w_st   <= W_IDLE;
      rgnt   <= '0;
      wgnt   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      r_st   <= r_nxt;
      w_st   <= w_nxt;
      rgnt   <= rgnt_nxt;
      wgnt   <= wgnt_nxt;
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
    end
  end
  always_comb begin
    r_nxt      = r_st;
    rgnt_nxt   = rgnt;
    rd_ptr_nxt = rd_ptr;
    m_ar_valid = 1'b0;
    s_ar_ready = '0;
    s_r_valid  = '0;
    m_r_ready  = 1'b0;
    case (r_st)
      R_IDLE: if (|s_ar_valid) begin
        rgnt_nxt = rr_pick(s_ar_valid, rd_ptr);
        r_nxt    = R_ADDR;
      end
      R_ADDR: begin
        m_ar_valid       = 1'b1;
        s_ar_ready[rgnt] = m_ar_ready;
        r_nxt            = m_ar_ready ? R_DATA : R_ADDR;
      end
      R_DATA: begin
        s_r_valid[rgnt] = m_r_valid;
        m_r_ready       = s_r_ready[rgnt];
        if (m_r_valid && m_r_ready && m_r_bits[IDW]) begin
          rd_ptr_nxt = nxt_ptr(rgnt);
          r_nxt      = R_IDLE;
        end
      end
      default: r_nxt = R_IDLE;
    endcase
  end
  always_comb begin
    w_nxt      = w_st;
    wgnt_nxt   = wgnt;
    wr_ptr_nxt = wr_ptr;
    m_aw_valid = 1'b0;
    s_aw_ready = '0;
    m_w_valid  = 1'b0;
    s_w_ready  = '0;
    s_b_valid  = '0;
    m_b_ready  = 1'b0;
    case (w_st)
      W_IDLE: if (|s_aw_valid) begin
        wgnt_nxt = rr_pick(s_aw_valid, wr_ptr);
        w_nxt    = W_ADDR;
      end
      W_ADDR: begin
        m_aw_valid       = 1'b1;
        s_aw_ready[wgnt] = m_aw_ready;
        w_nxt            = m_aw_ready ? W_DATA : W_ADDR;
      end
      W_DATA: begin
        m_w_valid       = s_w_valid[wgnt];
        s_w_ready[wgnt] = m_w_ready;
        w_nxt           = (m_w_valid && m_w_ready && w_sel[0]) ? W_RESP : W_DATA;
      end
      W_RESP: begin
        s_b_valid[wgnt] = m_b_valid;
        m_b_ready       = s_b_ready[wgnt];
        if (m_b_valid && m_b_ready) begin
          wr_ptr_nxt = nxt_ptr(wgnt);
          w_nxt      = W_IDLE;
        end
      end
      default: w_nxt = W_IDLE;
    endcase
  end
endmodule
